// File: rtl/mpu_pkg.sv
// Shared types and constants for the MPU result path: element/index types,
// streamer state encoding and the flattened-matrix offset helper.
package mpu_pkg;

  localparam int unsigned MPU_ELEM_W = 8;
  localparam int unsigned MPU_DIM    = 5;
  localparam int unsigned MPU_FLAT_W = MPU_DIM * MPU_DIM * MPU_ELEM_W;

  typedef logic [MPU_ELEM_W-1:0]         mpu_elem_t;
  typedef logic [2:0]                    mpu_idx_t;
  typedef logic [$clog2(MPU_FLAT_W)-1:0] mpu_off_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } mpu_stream_state_t;

  // Bit offset of element [i][j] inside a row-major flattened matrix.
  function automatic mpu_off_t elem_offset(input mpu_idx_t i, input mpu_idx_t j);
    return mpu_off_t'((int'(i) * int'(MPU_DIM) + int'(j)) * int'(MPU_ELEM_W));
  endfunction

endpackage

// File: rtl/mpu_index_counter.sv
// Row-major row/col counter with enable, synchronous clear and DIM-1 wrap.
// Also exposes the index that the next enabled step will load.
module mpu_index_counter
  import mpu_pkg::*;
#(
  parameter int unsigned DIM = MPU_DIM
) (
  input  logic     clk,
  input  logic     i_clr,
  input  logic     i_en,
  output mpu_idx_t o_row,
  output mpu_idx_t o_col,
  output mpu_idx_t o_nxt_row,
  output mpu_idx_t o_nxt_col,
  output logic     o_last
);

  localparam mpu_idx_t LAST = mpu_idx_t'(DIM - 1);

  always_comb begin
    o_nxt_row = o_row;
    o_nxt_col = o_col + 3'd1;
    if (o_col == LAST) begin
      o_nxt_col = '0;
      o_nxt_row = (o_row == LAST) ? '0 : o_row + 3'd1;
    end
  end

  assign o_last = (o_row == LAST) && (o_col == LAST);

  always_ff @(posedge clk) begin
    if (i_clr) begin
      o_row <= '0;
      o_col <= '0;
    end else if (i_en) begin
      o_row <= o_nxt_row;
      o_col <= o_nxt_col;
    end
  end

endmodule

// File: rtl/mpu_result_streamer.sv
// Captures a DIM x DIM result matrix on start and streams it row-major over
// valid/ready. Define MPU_STREAM_ABORT_EN to add the abort input.
module mpu_result_streamer
  import mpu_pkg::*;
#(
  parameter int unsigned ELEM_W = MPU_ELEM_W,
  parameter int unsigned DIM    = MPU_DIM
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [DIM*DIM*ELEM_W-1:0] matrix_in,
`ifdef MPU_STREAM_ABORT_EN
  input  logic                    abort,
`endif
  output logic                    busy,
  output logic [ELEM_W-1:0]       out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2:0]              out_row,
  output logic [2:0]              out_col,
  output logic                    done
);

  mpu_stream_state_t            r_state;
  logic [DIM*DIM*ELEM_W-1:0]    r_cap;
  logic [ELEM_W-1:0]            r_data;
  logic                         r_valid;
  logic                         r_busy;
  logic                         r_done;

  logic [ELEM_W-1:0] w_elem [DIM][DIM];
  logic              w_abort;
  logic              w_stream;
  logic              w_start;
  logic              w_xfer;
  logic              w_last;
  mpu_idx_t          w_row;
  mpu_idx_t          w_col;
  mpu_idx_t          w_nxt_row;
  mpu_idx_t          w_nxt_col;

`ifdef MPU_STREAM_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  for (genvar gi = 0; gi < DIM; gi++) begin : g_row
    for (genvar gj = 0; gj < DIM; gj++) begin : g_col
      assign w_elem[gi][gj] = r_cap[elem_offset(mpu_idx_t'(gi), mpu_idx_t'(gj)) +: ELEM_W];
    end
  end

  assign w_stream = (r_state == STREAM);
  assign w_start  = (r_state == IDLE) && start;
  assign w_xfer   = w_stream && r_valid && out_ready;

  mpu_index_counter #(.DIM(DIM)) u_idx (
    .clk       (clk),
    .i_clr     (reset || w_start || (w_stream && w_abort)),
    .i_en      (w_xfer && !w_abort),
    .o_row     (w_row),
    .o_col     (w_col),
    .o_nxt_row (w_nxt_row),
    .o_nxt_col (w_nxt_col),
    .o_last    (w_last)
  );

  // out_data is preloaded with the element the counter steps to, so it is
  // already aligned with out_row/out_col when they update on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_cap   <= matrix_in;
            r_data  <= matrix_in[ELEM_W-1:0];
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= STREAM;
          end
        end
        STREAM: begin
          if (w_abort) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (w_xfer) begin
            if (w_last) begin
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_data <= w_elem[w_nxt_row][w_nxt_col];
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign out_row   = w_row;
  assign out_col   = w_col;
  assign done      = r_done;

endmodule

// File: tb/tb_mpu_result_streamer.sv
// Randomized self-checking bench for mpu_result_streamer against a
// row-major element-list reference model.
module tb_mpu_result_streamer;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [199:0] matrix_in;
  logic         busy;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready;
  logic [2:0]   out_row;
  logic [2:0]   out_col;
  logic         done;
`ifdef MPU_STREAM_ABORT_EN
  logic         abort;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] m [25];

  always #5 clk = ~clk;

  mpu_result_streamer #(.ELEM_W(8), .DIM(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .matrix_in (matrix_in),
`ifdef MPU_STREAM_ABORT_EN
    .abort     (abort),
`endif
    .busy      (busy),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row   (out_row),
    .out_col   (out_col),
    .done      (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random();
    for (int k = 0; k < 25; k++) m[k] = 8'($urandom);
  endtask

  task automatic load_matrix();
    logic [199:0] flat;
    flat = '0;
    for (int k = 24; k >= 0; k--) flat = {flat[191:0], m[k]};
    matrix_in = flat;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy},      32'd0);
    check({tag, "_done"},  {31'd0, done},      32'd0);
  endtask

  task automatic begin_stream();
    load_matrix();
    start = 1'b1;
    tick();
    start = 1'b0;
    matrix_in = '1;
  endtask

  // mode 0: always ready, 1: random ready, 2: 3 stalls then alternating
  task automatic run_stream(input int mode, input int first_k);
    int k;
    int c;
    k = first_k;
    c = 0;
    while (k < 25 && c < 400) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (c < 3) ? 1'b0 : ((c - 3) % 2 == 0);
      endcase
      start = 1'($urandom_range(0, 1));
      matrix_in = (c % 2 == 0) ? '1 : '0;
      check("valid", {31'd0, out_valid}, 32'd1);
      check("busy",  {31'd0, busy},      32'd1);
      check("done_early", {31'd0, done}, 32'd0);
      check("row",   {29'd0, out_row},   32'(k / 5));
      check("col",   {29'd0, out_col},   32'(k % 5));
      check("data",  {24'd0, out_data},  {24'd0, m[k]});
      tick();
      if (out_ready) k++;
      c++;
    end
    if (k < 25) check("stream_timeout", 32'(k), 32'd25);
    start = 1'b0;
    if (mode == 0) check("cycles", 32'(c), 32'(25 - first_k));
    check("done_pulse", {31'd0, done},      32'd1);
    check("done_valid", {31'd0, out_valid}, 32'd0);
    check("done_busy",  {31'd0, busy},      32'd1);
    tick();
    check_idle("after_done");
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    matrix_in = '0;
`ifdef MPU_STREAM_ABORT_EN
    abort = 1'b0;
`endif
    tick();
    tick();
    check_idle("reset");
    check("reset_data", {24'd0, out_data}, 32'd0);
    check("reset_row",  {29'd0, out_row},  32'd0);
    check("reset_col",  {29'd0, out_col},  32'd0);
    reset = 1'b0;
    tick();
    check_idle("idle");

    // Ramp pattern with full throughput
    for (int k = 0; k < 25; k++) m[k] = 8'(k);
    begin_stream();
    run_stream(0, 0);

    // Backpressure on the same ramp
    begin_stream();
    run_stream(2, 0);

    // Wrap and saturation values under random ready
    fill_random();
    m[4]  = 8'h80;
    m[24] = 8'hFF;
    begin_stream();
    run_stream(1, 0);

    // Reset after 7 transfers
    fill_random();
    begin_stream();
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      check("pre_reset_data", {24'd0, out_data}, {24'd0, m[k]});
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 1'b0;
    check_idle("mid_reset");
    check("mid_reset_row", {29'd0, out_row}, 32'd0);
    check("mid_reset_col", {29'd0, out_col}, 32'd0);
    tick();
    check_idle("post_reset");
    fill_random();
    begin_stream();
    run_stream(1, 0);

`ifdef MPU_STREAM_ABORT_EN
    // Abort with a simultaneous transfer at element 10
    fill_random();
    begin_stream();
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    check("pre_abort_data", {24'd0, out_data}, {24'd0, m[10]});
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle("abort");
    tick();
    check_idle("post_abort");
    fill_random();
    begin_stream();
    run_stream(0, 0);
`endif

    for (int r = 0; r < 3; r++) begin
      fill_random();
      begin_stream();
      run_stream(1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mpu_result_streamer.md
Name: mpu_result_streamer

Overview:
Reads a full 5x5 result matrix produced by the MPU arithmetic datapath (e.g. the matrix adder) and streams it out one 8-bit element per transfer, row-major, over a valid/ready interface. It is the reader end of the matrix result bus: it captures the whole matrix on a start strobe, so the datapath inputs may change immediately afterwards. It sits between the MPU compute stage and the host or bus-facing interface.

Parameters:
ELEM_W, 8, element width in bits
DIM, 5, matrix dimension (rows = cols = DIM)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  capture matrix_in and begin streaming (honoured only in IDLE)
matrix_in  input  DIM*DIM*ELEM_W  flattened result matrix; element [i][j] at bits [(i*DIM+j)*ELEM_W +: ELEM_W]
busy  output  1  high from the capture cycle until return to IDLE
out_data  output  ELEM_W  current element
out_valid  output  1  out_data holds a valid element
out_ready  input  1  consumer accepts out_data when out_valid is also high
out_row  output  3  row index of out_data
out_col  output  3  column index of out_data
done  output  1  one-cycle pulse after the last element is transferred

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset). Reset has priority over every other input.
- Reset values: busy=0, out_valid=0, done=0, out_data=0, out_row=0, out_col=0, state=IDLE. The capture register contents are don't-care.
- States: IDLE, STREAM, DONE.
- IDLE: if start=1, latch matrix_in into the capture register at that edge and go to STREAM with row=0, col=0.
  - Next cycle: busy=1, out_valid=1, out_data=element[0][0].
  - Latency from start to first valid element is 1 cycle.
- STREAM:
  - out_valid=1 in this state.
  - A transfer occurs in any cycle where out_valid and out_ready are both high.
  - On a transfer, col increments. When col reaches DIM-1 it wraps to 0 and row increments.
  - With out_valid=1 and out_ready=0, out_data, out_row and out_col hold stable. out_valid never drops without a transfer.
  - A transfer at (DIM-1, DIM-1) moves the block to DONE.
- DONE: lasts one cycle, with done=1, out_valid=0, busy=1. The block then enters IDLE with busy=0.
- start is ignored in STREAM and DONE. No queuing.
- The captured matrix is unaffected by matrix_in changes after the capture edge.
- out_data is driven from a registered mux of the capture register by the row/col index.
- Throughput: with out_ready held high, the 25 elements take 25 consecutive cycles.
  - Start to done pulse: 26 cycles (start edge, 25 transfers, done cycle).
- Elements are passed through unmodified. No arithmetic.
- Reset asserted mid-stream: return to IDLE next edge, out_valid=0, no done pulse. The partially streamed matrix is discarded.

Optional Feature:
Macro MPU_STREAM_ABORT_EN.
- Defined: adds input abort (1 bit).
  - abort=1 in STREAM: IDLE at the next edge, out_valid=0, busy=0, no done pulse.
  - abort has priority over a simultaneous transfer.
  - abort in IDLE or DONE is ignored.
- Undefined: no abort port. Streaming always completes unless reset is asserted.

Decomposition:
- Shared package mpu_pkg, holding:
  - MPU_ELEM_W=8 and MPU_DIM=5;
  - typedef mpu_elem_t (logic [7:0]);
  - typedef mpu_idx_t (logic [2:0]);
  - enum mpu_stream_state_t {IDLE, STREAM, DONE};
  - the flattening index function elem_offset(i,j).
- One sub-module: mpu_index_counter.
  - Row/col counter with enable, synchronous clear and DIM-1 wrap.
  - Outputs row, col and last (asserted at (DIM-1, DIM-1)).

Test Plan:
- Capture and stream: matrix_in element[i][j]=i*5+j, start pulse, out_ready=1 -> out_data 0..24 in consecutive cycles; out_row/out_col match; done pulses on cycle 26; busy low after.
- Backpressure: stream starts with out_ready=0 for 3 cycles, then toggles 1/0 -> element[0][0]=0x00 held stable while stalled; every element delivered exactly once, in order.
- Input isolation: after start, change matrix_in to all 0xFF -> streamed values still 0..24; start re-pulsed mid-stream is ignored.
- Wrap and saturation values: element[4][4]=0xFF, element[0][4]=0x80 -> out_row/out_col go (0,4) to (1,0); (4,4) emits 0xFF, then done=1 and out_valid=0.
- Reset mid-stream: reset asserted after 7 transfers -> next cycle out_valid=0, busy=0, no done pulse; a new start restreams from element[0][0].
- With MPU_STREAM_ABORT_EN: abort together with out_ready=1 at element 10 -> no transfer counted, IDLE next cycle, no done pulse; the next start streams cleanly.
